// File: rtl/xmit_pkg.sv
// Shared types and constants for the two-requester serial transmit controller.
package xmit_pkg;

  localparam int XMIT_DATA_W     = 8;
  localparam int XMIT_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } xmit_state_e;

  typedef struct packed {
    logic                   valid;
    logic [XMIT_DATA_W-1:0] data;
  } xmit_req_t;

endpackage

// File: rtl/xmit_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and strobes bit_done on the last count.
module xmit_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_done
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_done = (cnt == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (clear || bit_done) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/xmit_ctrl.sv
// Round-robin arbiter for two byte requesters feeding an 8N1 serial framer.
module xmit_ctrl
  import xmit_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic [XMIT_DATA_W-1:0] req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [XMIT_DATA_W-1:0] req1_data,
  output logic                   req1_ready,
  output logic                   tx_out,
  output logic                   busy,
  output logic                   grant_id
);

  xmit_state_e            state, state_nxt;
  logic [XMIT_DATA_W-1:0] shreg;
  logic [2:0]             bit_idx;
  logic                   rr_ptr;
  logic                   bit_done, clear;
  logic                   gnt0, gnt1, accept;
  xmit_req_t              req0, req1, sel;

  assign req0 = '{valid: req0_valid, data: req0_data};
  assign req1 = '{valid: req1_valid, data: req1_data};

  // Grants only in IDLE; rst masks them so ready is low for the whole reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0.valid && req1.valid) begin
        gnt1 = rr_ptr;
        gnt0 = !rr_ptr;
      end else begin
        gnt0 = req0.valid;
        gnt1 = req1.valid;
      end
    end
  end

  assign accept     = gnt0 | gnt1;
  assign sel        = gnt1 ? req1 : req0;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)                     state_nxt = START;
      START:   if (bit_done)                   state_nxt = DATA;
      DATA:    if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (bit_done)                   state_nxt = IDLE;
      default:                                 state_nxt = IDLE;
    endcase
  end

  // Timer held at zero in IDLE and restarted on every state change.
  assign clear = (state_nxt != state) || (state == IDLE);

  xmit_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      rr_ptr   <= 1'b0;
      grant_id <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        shreg    <= sel.data;
        bit_idx  <= '0;
        grant_id <= gnt1;
        rr_ptr   <= !gnt1;
      end else if (state == DATA && bit_done) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    busy   = (state != IDLE);
    tx_out = 1'b1;
    case (state)
      START:   tx_out = 1'b0;
      DATA:    tx_out = shreg[0];
      default: tx_out = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_xmit_ctrl.sv
// Bench: two instances (4 and 2 clocks per bit) checked every cycle against a frame-level model.
module tb_xmit_ctrl;
  import xmit_pkg::*;

  localparam int CPB0 = 4;
  localparam int CPB1 = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] v0, v1, r0, r1, tx, bz, gid;
  logic [1:0][7:0] d0, d1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xmit_ctrl #(.CLKS_PER_BIT(CPB0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req0_valid(v0[0]), .req0_data(d0[0]), .req0_ready(r0[0]),
    .req1_valid(v1[0]), .req1_data(d1[0]), .req1_ready(r1[0]),
    .tx_out(tx[0]), .busy(bz[0]), .grant_id(gid[0])
  );

  xmit_ctrl #(.CLKS_PER_BIT(CPB1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(v0[1]), .req0_data(d0[1]), .req0_ready(r0[1]),
    .req1_valid(v1[1]), .req1_data(d1[1]), .req1_ready(r1[1]),
    .tx_out(tx[1]), .busy(bz[1]), .grant_id(gid[1])
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is 10 bit slots of C cycles (start, 8 data LSB first, stop).
  bit         m_busy [2];
  int         m_pos  [2];
  logic [7:0] m_byte [2];
  bit         m_ptr  [2];
  bit         m_gid  [2];

  always @(negedge clk) begin
    int c, k;
    logic e_tx, e_r0, e_r1, g;
    for (int i = 0; i < 2; i++) begin
      c = (i == 0) ? CPB0 : CPB1;
      if (rst) begin
        chk("rst_tx",   tx[i],  1'b1);
        chk("rst_busy", bz[i],  1'b0);
        chk("rst_rdy",  {r0[i], r1[i]}, 2'b00);
        chk("rst_gid",  gid[i], 1'b0);
        m_busy[i] = 0; m_ptr[i] = 0; m_gid[i] = 0; m_pos[i] = 0;
      end else begin
        e_r0 = 0; e_r1 = 0; g = 0; e_tx = 1;
        if (!m_busy[i]) begin
          if (v0[i] || v1[i]) begin
            g    = (v0[i] && v1[i]) ? m_ptr[i] : v1[i];
            e_r0 = !g;
            e_r1 = g;
          end
        end else begin
          k    = m_pos[i] / c;
          e_tx = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : m_byte[i][k-1];
        end
        chk("tx_out",   tx[i],  e_tx);
        chk("busy",     bz[i],  m_busy[i]);
        chk("ready0",   r0[i],  e_r0);
        chk("ready1",   r1[i],  e_r1);
        chk("rdy_excl", r0[i] & r1[i], 1'b0);
        chk("grant_id", gid[i], m_gid[i]);
        if (e_r0 || e_r1) begin
          m_busy[i] = 1; m_pos[i] = 0;
          m_byte[i] = g ? d1[i] : d0[i];
          m_gid[i]  = g;
          m_ptr[i]  = !g;
        end else if (m_busy[i]) begin
          m_pos[i]++;
          if (m_pos[i] == XMIT_FRAME_BITS * c) m_busy[i] = 0;
        end
      end
    end
  end

  task automatic wait_rdy(input int i, input int j, output int n);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(j ? r1[i] : r0[i]) && n < 200);
    if (n >= 200) chk("rdy_timeout", 32'd0, 32'd1);
  endtask

  task automatic measure_busy(input int i, output int n);
    int g;
    n = 0; g = 0;
    do begin @(negedge clk); g++; end while (!bz[i] && g < 100);
    while (bz[i] && n < 1000) begin n++; @(negedge clk); end
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
  endtask

  initial begin
    int n, cnt;
    int seq[$];
    logic [1:0] s0, s1;
    logic vv; logic [7:0] dd;
    v0 = '0; v1 = '0; d0 = '0; d1 = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // single 0xA5 frame
    @(posedge clk); #1 v0[0] = 1'b1; d0[0] = 8'hA5;
    wait_rdy(0, 0, n);
    @(posedge clk); #1 v0[0] = 1'b0;
    measure_busy(0, n);
    chk("a5_busy_len", n, 40);

    // contention after reset: req0 first, req1 one frame plus one idle cycle later
    do_reset();
    #1 v0[0] = 1'b1; d0[0] = 8'h11; v1[0] = 1'b1; d1[0] = 8'h22;
    wait_rdy(0, 0, n);
    chk("contend_first_r1", r1[0], 1'b0);
    @(posedge clk); #1 v0[0] = 1'b0;
    wait_rdy(0, 1, n);
    chk("contend_gap", n, 41);
    @(posedge clk); #1 v1[0] = 1'b0;

    // fairness: both held for six frames
    do_reset();
    #1 v0[0] = 1'b1; v1[0] = 1'b1;
    cnt = 0;
    while (seq.size() < 6 && cnt < 600) begin
      @(negedge clk); cnt++;
      if (r0[0]) seq.push_back(0);
      if (r1[0]) seq.push_back(1);
    end
    chk("fair_count", seq.size(), 6);
    for (int k = 0; k < seq.size(); k++) chk("fair_seq", seq[k], k % 2);
    @(posedge clk); #1 v0[0] = 1'b0; v1[0] = 1'b0;
    measure_busy(0, n);

    // req1 raised during DATA of a req0 frame waits for the next IDLE cycle
    @(posedge clk); #1 v0[0] = 1'b1; d0[0] = 8'h5A;
    wait_rdy(0, 0, n);
    @(posedge clk); #1 v0[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1 v1[0] = 1'b1; d1[0] = 8'hC3;
    wait_rdy(0, 1, n);
    chk("ignore_busy", n, 33);
    @(posedge clk); #1 v1[0] = 1'b0;
    measure_busy(0, n);

    // asynchronous reset during data bit 3
    @(posedge clk); #1 v0[0] = 1'b1; d0[0] = 8'h96;
    wait_rdy(0, 0, n);
    @(posedge clk); #1 v0[0] = 1'b0;
    repeat (16) @(posedge clk);
    #1 chk("pre_rst_busy", bz[0], 1'b1);
    #1 rst = 1'b1;
    #1 chk("async_rst_tx", tx[0], 1'b1);
    chk("async_rst_busy", bz[0], 1'b0);
    v0[0] = 1'b1; d0[0] = 8'h3C;
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    wait_rdy(0, 0, n);
    chk("post_rst_accept", n, 1);
    @(posedge clk); #1 v0[0] = 1'b0;
    measure_busy(0, n);
    chk("3c_busy_len", n, 40);

    // two clocks per bit: 0xFF then 0x00
    @(posedge clk); #1 v0[1] = 1'b1; d0[1] = 8'hFF;
    wait_rdy(1, 0, n);
    @(posedge clk); #1 v0[1] = 1'b0;
    measure_busy(1, n);
    chk("ff_len_c2", n, 20);
    @(posedge clk); #1 v1[1] = 1'b1; d1[1] = 8'h00;
    wait_rdy(1, 1, n);
    @(posedge clk); #1 v1[1] = 1'b0;
    measure_busy(1, n);
    chk("00_len_c2", n, 20);

    // random traffic on both instances
    repeat (3000) begin
      @(negedge clk); s0 = r0; s1 = r1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          vv = j ? v1[i] : v0[i];
          dd = j ? d1[i] : d0[i];
          if (vv && (j ? s1[i] : s0[i])) begin
            if ($urandom_range(1) == 1) dd = 8'($urandom);
            else                        vv = 1'b0;
          end else if (vv && $urandom_range(15) == 0) begin
            vv = 1'b0;
          end else if (!vv && $urandom_range(3) == 0) begin
            vv = 1'b1; dd = 8'($urandom);
          end
          if (j == 1) begin v1[i] = vv; d1[i] = dd; end
          else        begin v0[i] = vv; d0[i] = dd; end
        end
      end
    end
    v0 = '0; v1 = '0;
    repeat (60) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
